winner_encoder: RTL
===================

WINNER_ENCODER -- requirements
Module: winner_encoder

Interface
REQ-001 Parameter MAX_ITER, default 1024, maximum RUN cycles before timeout.
REQ-002 Parameter INDEX_W, default 16, width of max_index.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; a new competition has been loaded into the datapath.
REQ-006 done  input  1  datapath done flag (exactly one neuron still nonzero).
REQ-007 active  input  4  per-neuron nonzero flags from the datapath (bit i = neuron i+1).
REQ-008 result_ready  input  1  consumer accepts the result.
REQ-009 result_valid  output  1  max_index and status are valid.
REQ-010 max_index  output  INDEX_W  zero-based index of the winning neuron.
REQ-011 iter_count  output  16  RUN cycles taken by the current or last run.
REQ-012 timeout  output  1  run ended by MAX_ITER without done.
REQ-013 no_winner  output  1  result taken with zero or multiple active flags.
REQ-014 busy  output  1  high in RUN.

Function
REQ-015 FSM states: IDLE, RUN, RESULT.
REQ-016 IDLE: start=1 -> RUN next cycle; iter_count, timeout and no_winner clear to 0.
REQ-017 RUN: iter_count increments by 1 each cycle and saturates at 16'hFFFF.
REQ-018 RUN: done is ignored while iter_count==0; this lets the datapath registers settle.
REQ-019 RUN: done=1 with iter_count>=1 -> capture active, encode and go to RESULT the next cycle.
REQ-020 Encoding: exactly one active bit i -> max_index=i, no_winner=0.
REQ-021 Encoding: multiple active bits -> max_index = lowest set index, no_winner=1.
REQ-022 Encoding: active==0 -> max_index = all ones (16'hFFFF), no_winner=1.
REQ-023 RUN: iter_count reaches MAX_ITER with no done -> RESULT, timeout=1, max_index = all ones, no_winner=1.
REQ-024 If done and the MAX_ITER limit occur in the same cycle, done wins and timeout=0.
REQ-025 RUN: start=1 restarts the run: iter_count=0, state stays RUN, any done in that cycle is ignored.
REQ-026 RESULT: result_valid=1; max_index, timeout, no_winner and iter_count are held stable.
REQ-027 RESULT: result_valid & result_ready -> IDLE next cycle; result_valid drops that cycle.
REQ-028 RESULT: start is ignored until the result is accepted; no result is dropped.
REQ-029 IDLE: done and active are ignored.
REQ-030 Latency: result_valid rises exactly 1 cycle after the qualifying done sample.
REQ-031 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-032 rst=1 at a clock edge -> IDLE; result_valid=0, busy=0, max_index=0, iter_count=0, timeout=0, no_winner=0.
REQ-033 Reset has priority over start, done and result_ready in the same cycle.
REQ-034 Reset mid-RUN or mid-RESULT discards the run; no result is emitted.

Structure
REQ-035 Shared package holds: state enum (IDLE/RUN/RESULT), NO_WINNER constant (all ones), neuron count constant 4.
REQ-036 One sub-module, winner_prio_enc: combinational 4-bit lowest-index priority encoder with outputs index, multi and none.

Verification
REQ-037 start; active=4'b0100, done=1 at RUN cycle 3 -> result_valid next cycle, max_index=2, iter_count=3, no_winner=0, timeout=0.
REQ-038 start; done=1 at iter_count==0 then 0; done=1 with active=4'b0001 at cycle 5 -> first done ignored, max_index=0.
REQ-039 MAX_ITER=8; start, never done -> after 8 RUN cycles result_valid=1, timeout=1, max_index=16'hFFFF.
REQ-040 done with active=4'b1010 -> max_index=1, no_winner=1; done with active=0 -> max_index=16'hFFFF, no_winner=1.
REQ-041 In RESULT, result_ready=0 for 5 cycles with start pulses -> outputs stable and start ignored; result_ready=1 -> IDLE next cycle.
REQ-042 rst=1 mid-RUN at cycle 4 with done=1 -> next cycle IDLE, all outputs 0, no result_valid pulse.

Source files
------------

// File: rtl/winner_encoder_pkg.sv
// Shared types and constants for the winner encoder controller.
package winner_encoder_pkg;

  localparam int unsigned NUM_NEURONS  = 4;
  localparam int unsigned NEURON_IDX_W = 2;

  // All-ones marker; wide enough to be sliced down to any index width in use.
  localparam logic [63:0] NO_WINNER = '1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StResult
  } state_e;

endpackage

// File: rtl/winner_prio_enc.sv
// Lowest-index-first priority encoder over the neuron active flags.
module winner_prio_enc
  import winner_encoder_pkg::*;
(
  input  logic [NUM_NEURONS-1:0]  i_active,
  output logic [NEURON_IDX_W-1:0] o_index,
  output logic                    o_multi,
  output logic                    o_none
);

  always_comb begin
    o_index = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (i_active[i]) o_index = NEURON_IDX_W'(i);
    end
    o_none  = (i_active == '0);
    o_multi = ((i_active & (i_active - 1'b1)) != '0);
  end

endmodule

// File: rtl/winner_encoder.sv
// Run/timeout controller that waits for the datapath to settle on one neuron and
// reports its index with a valid/ready handshake.
module winner_encoder
  import winner_encoder_pkg::*;
#(
  parameter int unsigned MAX_ITER = 1024,
  parameter int unsigned INDEX_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_done,
  input  logic [NUM_NEURONS-1:0] i_active,
  input  logic                   i_result_ready,
  output logic                   o_result_valid,
  output logic [INDEX_W-1:0]     o_max_index,
  output logic [15:0]            o_iter_count,
  output logic                   o_timeout,
  output logic                   o_no_winner,
  output logic                   o_busy
);

  localparam logic [INDEX_W-1:0] NoWinIdx = NO_WINNER[INDEX_W-1:0];

  state_e                r_state;
  logic                  r_result_valid;
  logic [INDEX_W-1:0]    r_max_index;
  logic [15:0]           r_iter;
  logic                  r_timeout;
  logic                  r_no_winner;
  logic                  r_busy;

  logic [NEURON_IDX_W-1:0] w_idx;
  logic                    w_multi;
  logic                    w_none;
  logic [15:0]             w_iter_inc;
  logic                    w_limit;

  winner_prio_enc u_prio_enc (
    .i_active (i_active),
    .o_index  (w_idx),
    .o_multi  (w_multi),
    .o_none   (w_none)
  );

  assign w_iter_inc = (r_iter == 16'hFFFF) ? r_iter : r_iter + 16'd1;
  assign w_limit    = (32'(w_iter_inc) >= MAX_ITER);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_result_valid <= 1'b0;
      r_max_index    <= '0;
      r_iter         <= '0;
      r_timeout      <= 1'b0;
      r_no_winner    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state     <= StRun;
            r_busy      <= 1'b1;
            r_iter      <= '0;
            r_timeout   <= 1'b0;
            r_no_winner <= 1'b0;
          end
        end
        StRun: begin
          if (i_start) begin
            r_iter <= '0;
          end else begin
            r_iter <= w_iter_inc;
            // The first RUN cycle still sees stale datapath state, so done waits a cycle.
            if (i_done && (r_iter != 16'd0)) begin
              r_state        <= StResult;
              r_busy         <= 1'b0;
              r_result_valid <= 1'b1;
              r_max_index    <= w_none ? NoWinIdx : INDEX_W'(w_idx);
              r_no_winner    <= w_none | w_multi;
            end else if (w_limit) begin
              r_state        <= StResult;
              r_busy         <= 1'b0;
              r_result_valid <= 1'b1;
              r_max_index    <= NoWinIdx;
              r_timeout      <= 1'b1;
              r_no_winner    <= 1'b1;
            end
          end
        end
        StResult: begin
          if (i_result_ready) begin
            r_state        <= StIdle;
            r_result_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_result_valid = r_result_valid;
  assign o_max_index    = r_max_index;
  assign o_iter_count   = r_iter;
  assign o_timeout      = r_timeout;
  assign o_no_winner    = r_no_winner;
  assign o_busy         = r_busy;

endmodule
